// File: rtl/dense_output_layer.sv
// -----------------------------------------------------------------------------
// dense_output_layer
//
// Fully-connected output stage for the LSTM hidden vector. OUTPUT_SZ neurons
// run as parallel MAC lanes. One hidden element is consumed per cycle, so a
// sample takes HIDDEN_SZ + 2 cycles: one load cycle, HIDDEN_SZ MAC cycles and
// one finalise cycle. Each lane has its own weight row and bias. Each lane
// also has a saturating Q(QN.QM) output with optional ReLU.
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low reset
//   hiddenVec      HIDDEN_SZ packed signed elements, element i at [i*BW +: BW]
//   start          request one inference (sampled only while idle)
//   relu_en        activation select latched with start (1 = ReLU)
//   wrEn           weight/bias write strobe (honoured only while idle)
//   wrRow          neuron index
//   wrCol          weight column, HIDDEN_SZ addresses the bias
//   wrData         signed Q(QN.QM) value to write
//   busy           high while computing (RUN or FINAL)
//   dataReady      one-cycle pulse when networkOutput updates
//   networkOutput  OUTPUT_SZ packed results, neuron o at [o*BW +: BW]
//   satFlag        per-neuron clip indicator for the last result
// -----------------------------------------------------------------------------
module dense_output_layer #(
  parameter int HIDDEN_SZ = 32,
  parameter int OUTPUT_SZ = 4,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int ROW_AW    = 2,
  parameter int COL_AW    = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [(QN+QM+1)*HIDDEN_SZ-1:0]     hiddenVec,
  input  logic                               start,
  input  logic                               relu_en,
  input  logic                               wrEn,
  input  logic [ROW_AW-1:0]                  wrRow,
  input  logic [COL_AW-1:0]                  wrCol,
  input  logic [QN+QM:0]                     wrData,
  output logic                               busy,
  output logic                               dataReady,
  output logic [(QN+QM+1)*OUTPUT_SZ-1:0]     networkOutput,
  output logic [OUTPUT_SZ-1:0]               satFlag
);

  localparam int BW     = QN + QM + 1;
  // The worst-case sum of HIDDEN_SZ full products plus the shifted bias fits
  // without wrapping.
  localparam int ACC_W  = 2*BW + $clog2(HIDDEN_SZ+1) + 1;
  localparam int CIDX_W = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;

  // Output range expressed at accumulator width, so the clip test is a plain
  // signed compare on the shifted sum.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-BW+1){1'b1}}, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  state_t                  state_q;
  logic [COL_AW-1:0]       col_q;
  logic                    relu_q;
  logic                    data_ready_q;
  logic [BW*HIDDEN_SZ-1:0] hid_q;
  logic                    wr_ok;

  // Writes are accepted only while idle. Row and column matching is done
  // per register below, so any out-of-range address simply hits nothing.
  assign wr_ok = (state_q == ST_IDLE) && wrEn;

  // ---------------------------------------------------------------------------
  // Control FSM: sequences load, MAC and finalise phases.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      relu_q       <= 1'b0;
      data_ready_q <= 1'b0;
      hid_q        <= '0;
    end else begin
      data_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            hid_q   <= hiddenVec;
            relu_q  <= relu_en;
            col_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          col_q <= col_q + COL_AW'(1);
          if (col_q == COL_AW'(HIDDEN_SZ-1)) begin
            state_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          data_ready_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dataReady = data_ready_q;

  // The latched hidden vector is unpacked so the current column can be
  // selected once and shared by every lane.
  logic signed [BW-1:0] h_arr [HIDDEN_SZ];
  logic signed [BW-1:0] h_sel;

  genvar gi;
  generate
    for (gi = 0; gi < HIDDEN_SZ; gi++) begin : g_hid
      assign h_arr[gi] = hid_q[gi*BW +: BW];
    end
  endgenerate

  assign h_sel = h_arr[col_q[CIDX_W-1:0]];

  // ---------------------------------------------------------------------------
  // One MAC lane per output neuron.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < OUTPUT_SZ; gi++) begin : g_lane
      logic signed [BW-1:0]    w_q [HIDDEN_SZ];
      logic signed [BW-1:0]    bias_q;
      logic signed [BW-1:0]    w_sel;
      logic signed [2*BW-1:0]  prod;
      logic signed [ACC_W-1:0] prod_ext;
      logic signed [ACC_W-1:0] bias_ext;
      logic signed [ACC_W-1:0] acc_q;
      logic signed [ACC_W-1:0] acc_shr;
      logic                    pos_clip;
      logic                    neg_clip;
      logic signed [BW-1:0]    sat_val;
      logic signed [BW-1:0]    res_d;
      logic [BW-1:0]           out_q;
      logic                    sat_q;

      // The weight row and bias are cleared by reset, so they are plain
      // registers and not RAM.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int c = 0; c < HIDDEN_SZ; c++) begin
            w_q[c] <= '0;
          end
          bias_q <= '0;
        end else if (wr_ok && (wrRow == ROW_AW'(gi))) begin
          if (wrCol == COL_AW'(HIDDEN_SZ)) begin
            bias_q <= wrData;
          end
          for (int c = 0; c < HIDDEN_SZ; c++) begin
            if (wrCol == COL_AW'(c)) begin
              w_q[c] <= wrData;
            end
          end
        end
      end

      assign w_sel    = w_q[col_q[CIDX_W-1:0]];
      assign prod     = w_sel * h_sel;
      assign prod_ext = {{(ACC_W-2*BW){prod[2*BW-1]}}, prod};
      // The bias is aligned to the product's 2*QM fraction bits.
      assign bias_ext = {{(ACC_W-BW-QM){bias_q[BW-1]}}, bias_q, {QM{1'b0}}};
      assign acc_shr  = acc_q >>> QM;
      assign pos_clip = (acc_shr > OUT_MAX);
      assign neg_clip = (acc_shr < OUT_MIN);

      always_comb begin
        sat_val = acc_shr[BW-1:0];
        if (pos_clip) begin
          sat_val = OUT_MAX[BW-1:0];
        end else if (neg_clip) begin
          sat_val = OUT_MIN[BW-1:0];
        end
        // ReLU acts on the already-clipped value.
        res_d = sat_val;
        if (relu_q && sat_val[BW-1]) begin
          res_d = '0;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          acc_q <= '0;
          out_q <= '0;
          sat_q <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // The bias is read before any same-cycle write lands.
              if (start) begin
                acc_q <= bias_ext;
              end
            end
            ST_RUN: begin
              acc_q <= acc_q + prod_ext;
            end
            ST_FINAL: begin
              out_q <= res_d;
              sat_q <= pos_clip | neg_clip;
            end
            default: ;
          endcase
        end
      end

      assign networkOutput[gi*BW +: BW] = out_q;
      assign satFlag[gi]                = sat_q;
    end
  endgenerate

endmodule
